// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// No logic; constants, FSM state encoding and an index-width helper.
// Imported by the arbiter interface, the round-robin picker and the top.
package uart_pkg;

    localparam int UART_ARB_N_REQ        = 4;
    localparam int UART_ARB_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } uart_arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester lanes plus the transmitter-facing signals.
// slave  : arbiter side (takes requests, drives the transmitter).
// master : requester/transmitter side.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ = UART_ARB_N_REQ
) ();

    logic [N_REQ-1:0]          req_valid;
    logic [8*N_REQ-1:0]        req_data;
    logic [N_REQ-1:0]          req_last;
    logic [N_REQ-1:0]          req_ready;
    logic [7:0]                tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [idx_w(N_REQ)-1:0]   grant_id;
    logic                      locked;
    logic                      err_timeout;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, locked, err_timeout
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, locked, err_timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin picker: first set request bit at or above i_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own state.
// Ports: i_req request vector, i_ptr scan start, o_gnt one-hot grant,
//        o_idx encoded grant, o_any at least one request present.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    // One extra bit so ptr+i cannot overflow before the wrap subtraction.
    logic [W:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, i_ptr} + (W+1)'(i);
            if (w_pos >= (W+1)'(N)) begin
                w_pos = w_pos - (W+1)'(N);
            end
            if (!o_any && i_req[w_pos[W-1:0]]) begin
                o_any               = 1'b1;
                o_gnt[w_pos[W-1:0]] = 1'b1;
                o_idx               = w_pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte streams, round-robin per packet.
// Latency: accept at T, tx_start at T+1, first busy check at T+2.
// Backpressure: req_ready only in IDLE with tx_busy low; lock holds the grant.
// Ports: clk, rst_n (async active-low); arb.slave carries requester lanes
//        (valid/data/last/ready), transmitter start/data/busy, and status
//        grant_id, locked, err_timeout (one-cycle watchdog abort pulse).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = UART_ARB_N_REQ,
    parameter int BUSY_TIMEOUT = UART_ARB_BUSY_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave arb
);

    localparam int GW = idx_w(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    uart_arb_state_t r_state;
    uart_arb_state_t w_state_nxt;

    logic [7:0]       r_tx_data;
    logic [GW-1:0]    r_grant_id;
    logic [GW-1:0]    r_rr_ptr;
    logic             r_locked;
    logic [CW-1:0]    r_wd_cnt;

    logic [N_REQ-1:0] w_rr_gnt;
    logic [GW-1:0]    w_rr_idx;
    logic             w_rr_any;

    logic             w_cand_vld;
    logic [GW-1:0]    w_cand_idx;
    logic [7:0]       w_cand_data;
    logic             w_cand_last;
    logic             w_accept;
    logic             w_abort;
    logic             w_done;
    logic [N_REQ-1:0] w_ready;
    logic [GW-1:0]    w_ptr_nxt;

    rr_arbiter #(
        .N (N_REQ),
        .W (GW)
    ) u_rr (
        .i_req (arb.req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // While a packet is in progress only the owner may be served; the
    // round-robin result is ignored even if other lanes are waiting.
    always_comb begin
        w_cand_idx  = w_rr_idx;
        w_cand_vld  = w_rr_any;
        if (r_locked) begin
            w_cand_idx = r_grant_id;
            w_cand_vld = arb.req_valid[r_grant_id];
        end
        w_cand_data = '0;
        w_cand_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_cand_idx == GW'(i)) begin
                w_cand_data = arb.req_data[8*i +: 8];
                w_cand_last = arb.req_last[i];
            end
        end
    end

    // rst_n gates the combinational strobe so nothing looks accepted while
    // the block is held in reset.
    assign w_accept = rst_n && (r_state == S_IDLE) && !arb.tx_busy && w_cand_vld;

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            if (r_locked) begin
                w_ready[r_grant_id] = 1'b1;
            end else begin
                w_ready = w_rr_gnt;
            end
        end
    end

    assign w_ptr_nxt = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A late busy on the timeout cycle still counts as success.
                if (arb.tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_wd_cnt == CW'(BUSY_TIMEOUT)) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!arb.tx_busy) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_locked   <= 1'b0;
            r_wd_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_tx_data  <= w_cand_data;
                r_grant_id <= w_cand_idx;
                r_locked   <= ~w_cand_last;
            end

            if (r_state == S_START) begin
                r_wd_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            // Pointer moves only at packet boundaries (normal end or abort).
            if (w_abort) begin
                r_locked <= 1'b0;
                r_rr_ptr <= w_ptr_nxt;
            end else if (w_done && !r_locked) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign arb.req_ready   = w_ready;
    assign arb.tx_data     = r_tx_data;
    assign arb.tx_start    = (r_state == S_START);
    assign arb.grant_id    = r_grant_id;
    assign arb.locked      = r_locked;
    assign arb.err_timeout = w_abort;

endmodule
